visintegrate: RTL and testbench

- Sits directly downstream of the correlator-chain accumulator and consumes its partial-visibility stream (`vis_*`).
- Integrates each of NVIS complex visibilities over COUNT consecutive frames into a working RAM.
- Writes the final sums into a double-buffered output bank, then streams them out over a valid/ready interface to the readout/SPI/AXI stage.
- The upstream stream cannot be stalled, so output back-pressure is absorbed by bank double-buffering and an overflow flag.

---
 rtl/visintegrate.sv | 145 ++++++++++++++
 tb/tb_visintegrate.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/visintegrate.sv
// visintegrate: integrates NVIS complex visibilities over COUNT frames and streams the sums out of a double-buffered bank.
module visintegrate #(
    parameter int IBITS = 6,
    parameter int OBITS = 24,
    parameter int NVIS  = 32,
    parameter int COUNT = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 vis_valid_i,
    input  logic                 vis_first_i,
    input  logic                 vis_last_i,
    input  logic [IBITS-1:0]     vis_real_i,
    input  logic [IBITS-1:0]     vis_imag_i,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic [2*OBITS-1:0]   m_tdata,
    output logic                 overflow_o,
    output logic                 error_o,
    output logic                 busy_o
);
    localparam int ABITS = $clog2(NVIS);
    localparam int CBITS = COUNT > 1 ? $clog2(COUNT) : 1;
    localparam int DW = 2 * OBITS;
    localparam logic [ABITS-1:0] LAST_IDX = ABITS'(NVIS - 1);
    localparam logic [CBITS-1:0] LAST_F = CBITS'(COUNT - 1);
    localparam logic [ABITS:0] RD_END = (ABITS + 1)'(NVIS);
    localparam logic [ABITS:0] RD_LAST = (ABITS + 1)'(NVIS - 1);

    logic [ABITS-1:0] idx, eff_idx;
    logic [CBITS-1:0] fcnt;
    logic bad_first, at_end, frame_end, bad_frame;
    logic s0_valid, s0_end, s0_fz, s0_fl;
    logic [ABITS-1:0] s0_idx;
    logic signed [IBITS-1:0] s0_re, s0_im;
    logic [DW-1:0] ram [2**ABITS];
    logic [DW-1:0] ram_q;
    logic [DW-1:0] bank_mem [2**(ABITS+1)];
    logic [OBITS-1:0] sum_re, sum_im;
    logic wr_work, wr_bank, done;
    logic wbank;
    logic [ABITS:0] rd_cnt;
    logic rd_v, rd_ql;
    logic [DW-1:0] rd_q;
    logic [DW-1:0] fifo [2];
    logic [1:0] fifo_l;
    logic wp, rp;
    logic [1:0] cnt;
    logic [2:0] occ;
    logic pop, finish, idle, swap, issue;

    always_comb begin
        bad_first = vis_first_i && idx != '0;
        eff_idx = bad_first ? '0 : idx;
        at_end = eff_idx == LAST_IDX;
        frame_end = vis_last_i || at_end;
        bad_frame = bad_first || (vis_last_i != at_end);
        sum_re = (s0_fz ? '0 : ram_q[DW-1:OBITS]) + OBITS'(s0_re);
        sum_im = (s0_fz ? '0 : ram_q[OBITS-1:0]) + OBITS'(s0_im);
        wr_work = s0_valid && !s0_fl;
        wr_bank = s0_valid && s0_fl;
        done = wr_bank && s0_end;
        m_tvalid = cnt != 2'd0;
        m_tlast = m_tvalid && fifo_l[rp];
        m_tdata = fifo[rp];
        pop = m_tvalid && m_tready;
        finish = pop && m_tlast;
        idle = !busy_o || finish;
        swap = done && idle;
        occ = 3'(cnt) + 3'(rd_v) - 3'(pop);
        issue = busy_o && !finish && rd_cnt != RD_END && occ < 3'd2;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx <= '0;
            fcnt <= '0;
            error_o <= 1'b0;
            s0_valid <= 1'b0;
            s0_idx <= '0;
            s0_re <= '0;
            s0_im <= '0;
            s0_end <= 1'b0;
            s0_fz <= 1'b0;
            s0_fl <= 1'b0;
        end else begin
            if (vis_valid_i) begin
                idx <= frame_end ? '0 : eff_idx + 1'b1;
                fcnt <= !frame_end ? fcnt : fcnt == LAST_F ? '0 : fcnt + 1'b1;
                error_o <= error_o | bad_frame;
            end
            s0_valid <= vis_valid_i;
            s0_idx <= eff_idx;
            s0_re <= vis_real_i;
            s0_im <= vis_imag_i;
            s0_end <= frame_end;
            s0_fz <= fcnt == '0;
            s0_fl <= fcnt == LAST_F;
        end
    end

    // Working RAM is read every cycle at the incoming index; the registered word lines up with S1.
    always_ff @(posedge clock) begin
        ram_q <= ram[eff_idx];
        if (wr_work) ram[s0_idx] <= {sum_re, sum_im};
        if (wr_bank) bank_mem[{wbank, s0_idx}] <= {sum_re, sum_im};
        if (issue) rd_q <= bank_mem[{~wbank, rd_cnt[ABITS-1:0]}];
    end

    // Reads are only issued while the in-flight read plus queued beats leave room in the 2-entry skid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wbank <= 1'b0;
            busy_o <= 1'b0;
            overflow_o <= 1'b0;
            rd_cnt <= '0;
            rd_v <= 1'b0;
            rd_ql <= 1'b0;
            fifo[0] <= '0;
            fifo[1] <= '0;
            fifo_l <= '0;
            wp <= 1'b0;
            rp <= 1'b0;
            cnt <= '0;
        end else begin
            wbank <= wbank ^ swap;
            busy_o <= swap ? 1'b1 : finish ? 1'b0 : busy_o;
            overflow_o <= overflow_o | (done && !idle);
            rd_v <= issue;
            if (swap) rd_cnt <= '0;
            if (issue) begin
                rd_cnt <= rd_cnt + 1'b1;
                rd_ql <= rd_cnt == RD_LAST;
            end
            if (rd_v) begin
                fifo[wp] <= rd_q;
                fifo_l[wp] <= rd_ql;
                wp <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + 2'(rd_v) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_visintegrate.sv
// tb_visintegrate: directed stimulus with a scoreboard of expected output beats for a 4-visibility, 2-frame configuration.
module tb_visintegrate;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic vis_valid_i = 1'b0, vis_first_i = 1'b0, vis_last_i = 1'b0;
    logic [5:0] vis_real_i = '0, vis_imag_i = '0;
    logic m_tready = 1'b1;
    logic m_tvalid, m_tlast, overflow_o, error_o, busy_o;
    logic [31:0] m_tdata;
    int passed = 0;
    int total = 0;
    logic [32:0] sb [$];
    logic [32:0] held, e;
    logic held_v = 1'b0;

    always #5 clock = ~clock;

    visintegrate #(.IBITS(6), .OBITS(16), .NVIS(4), .COUNT(2)) dut (
        .clock(clock), .reset(reset),
        .vis_valid_i(vis_valid_i), .vis_first_i(vis_first_i), .vis_last_i(vis_last_i),
        .vis_real_i(vis_real_i), .vis_imag_i(vis_imag_i),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
        .overflow_o(overflow_o), .error_o(error_o), .busy_o(busy_o)
    );

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic push(input logic l, input int r, input int i);
        sb.push_back({l, 16'(r), 16'(i)});
    endtask

    task automatic beat(input int r, input int i, input logic f, input logic l);
        vis_valid_i = 1'b1;
        vis_first_i = f;
        vis_last_i = l;
        vis_real_i = 6'(r);
        vis_imag_i = 6'(i);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        vis_valid_i = 1'b0;
        vis_first_i = 1'b0;
        vis_last_i = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic frame(input int r0, input int dr, input int i0, input int di);
        for (int k = 0; k < 4; k++) beat(r0 + k * dr, i0 + k * di, k == 0, k == 3);
    endtask

    task automatic integ(input int ra, input int dra, input int ia, input int dia,
                         input int rb, input int drb, input int ib, input int dib, input bit keep);
        if (keep)
            for (int k = 0; k < 4; k++)
                push(k == 3, ra + k * dra + rb + k * drb, ia + k * dia + ib + k * dib);
        frame(ra, dra, ia, dia);
        frame(rb, drb, ib, dib);
        idle(0);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || busy_o || m_tvalid) && n < 400) begin
            @(negedge clock);
            n++;
        end
        check(tag, {32'(sb.size()), busy_o, m_tvalid}, 34'd0);
        idle(1);
    endtask

    always @(negedge clock) begin
        if (reset) held_v <= 1'b0;
        else begin
            if (held_v) check("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, held});
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) check("extra_beat", {33'd0, m_tvalid}, 34'd0);
                else begin
                    e = sb.pop_front();
                    check("beat", {1'b0, m_tlast, m_tdata}, {1'b0, e});
                end
            end
            held_v <= m_tvalid && !m_tready;
            held <= {m_tlast, m_tdata};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_ctl", {29'd0, m_tvalid, m_tlast, overflow_o, error_o, busy_o}, 34'd0);
        check("rst_data", {2'b00, m_tdata}, 34'd0);
        reset = 1'b0;
        idle(2);

        integ(1, 1, -1, -1, 1, 1, -1, -1, 1);
        wait_drain("drain_basic");
        check("flags_basic", {32'd0, overflow_o, error_o}, 34'd0);

        integ(-32, 0, 31, 0, -32, 0, 31, 0, 1);
        integ(31, 0, -32, 0, 31, 0, -32, 0, 1);
        wait_drain("drain_extreme");
        check("ovf_extreme", {33'd0, overflow_o}, 34'd0);

        fork
            begin
                integ(3, 2, 5, -1, 3, 2, 5, -1, 1);
                idle(3);
                check("busy_stall", {33'd0, busy_o}, 34'd1);
                idle(20);
                integ(-10, 1, -2, 3, 4, 4, 0, 0, 1);
            end
            begin
                for (int k = 0; k < 80; k++) begin
                    m_tready = (k % 4 == 0) || (k % 4 == 3);
                    @(posedge clock);
                    #1;
                end
                m_tready = 1'b1;
            end
        join
        wait_drain("drain_bp");
        check("ovf_bp", {33'd0, overflow_o}, 34'd0);

        m_tready = 1'b0;
        integ(7, -3, 1, 1, 2, 2, -5, 0, 1);
        integ(20, 1, 0, 0, 9, 1, 9, 1, 0);
        idle(6);
        check("ovf_flag", {33'd0, overflow_o}, 34'd1);
        check("ovf_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b0, 16'(9), 16'(-4)});
        m_tready = 1'b1;
        wait_drain("drain_ovf");
        idle(10);
        check("ovf_dropped", {32'(sb.size()), m_tvalid, busy_o}, 34'd0);

        // Bad first at index 2 restarts at 0; the RAM ends up holding the restarted beats.
        check("err_clear", {33'd0, error_o}, 34'd0);
        beat(1, -1, 1, 0);
        beat(2, -2, 0, 0);
        beat(3, 3, 1, 0);
        beat(4, 4, 0, 0);
        beat(5, 5, 0, 0);
        beat(6, 6, 0, 1);
        idle(2);
        check("err_first", {33'd0, error_o}, 34'd1);
        push(0, 13, 2);
        push(0, 19, 3);
        push(0, 25, 4);
        push(1, 31, 5);
        frame(10, 5, -1, 0);
        idle(0);
        wait_drain("drain_err_first");

        m_tready = 1'b0;
        integ(5, 0, 5, 0, 5, 0, 5, 0, 0);
        frame(1, 0, 1, 0);
        beat(2, 2, 1, 0);
        beat(2, 2, 0, 0);
        idle(0);
        check("pre_rst", {30'd0, m_tvalid, busy_o, overflow_o, error_o}, 34'hf);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_ctl", {29'd0, m_tvalid, m_tlast, overflow_o, error_o, busy_o}, 34'd0);
        check("rst_mid_data", {2'b00, m_tdata}, 34'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_tready = 1'b1;
        idle(2);
        integ(2, 1, -3, 0, 1, 1, 1, 2, 1);
        wait_drain("drain_after_rst");
        check("flags_after_rst", {32'd0, overflow_o, error_o}, 34'd0);

        // Early last at index 1 ends frame 0; indices 2,3 then pick up the previous frame-0 RAM words.
        beat(7, 1, 1, 0);
        beat(8, 2, 0, 1);
        idle(2);
        check("err_last", {33'd0, error_o}, 34'd1);
        push(0, 8, 2);
        push(0, 10, 4);
        push(0, 7, 0);
        push(1, 9, 1);
        frame(1, 1, 1, 1);
        idle(0);
        wait_drain("drain_err_last");
        check("ovf_final", {33'd0, overflow_o}, 34'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
